// File: rtl/pe_ctrl_pkg.sv
// Shared types, default dimensions and timing helpers for the pe_array sequencer.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } state_e;

    localparam int DEF_MAC_NUM = 10;
    localparam int DEF_IA_H    = 100;
    localparam int DEF_IA_W    = 150;
    localparam int DEF_OA_W    = 16;
    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_PE_LAT  = 3;

    // Address width for a range of v values; never zero so size-1 loops still get a port.
    function automatic int clog2_1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // CLEAR + STREAM + DRAIN + one WRITE cycle when the writer is always ready.
    function automatic int tile_cycles(input int ia_w, input int rd_lat, input int pe_lat);
        return 1 + ia_w + rd_lat + pe_lat + 1;
    endfunction

endpackage

// File: rtl/pe_array_ctrl_if.sv
// Control, buffer-read, pe_array and output-write signals of the pe_array sequencer.
interface pe_array_ctrl_if
    import pe_ctrl_pkg::*;
#(
    parameter int MAC_NUM = DEF_MAC_NUM,
    parameter int IA_H    = DEF_IA_H,
    parameter int IA_W    = DEF_IA_W,
    parameter int OA_W    = DEF_OA_W
);
    localparam int TILE_W = clog2_1(IA_H / MAC_NUM);
    localparam int COL_W  = clog2_1(IA_W);
    localparam int OCOL_W = clog2_1(OA_W);
    localparam int ROW_W  = clog2_1(IA_H);

    logic              start;
    logic [7:0]        shift_cfg;
    logic              busy;
    logic              done;
    logic              act_rd_en;
    logic [TILE_W-1:0] act_rd_tile;
    logic [COL_W-1:0]  act_rd_col;
    logic              wet_rd_en;
    logic [COL_W-1:0]  wet_rd_row;
    logic [OCOL_W-1:0] wet_rd_col;
    logic              PE_mac_enable;
    logic              PE_clear_acc;
    logic [7:0]        PE_res_shift_num;
    logic              out_valid;
    logic              out_ready;
    logic [ROW_W-1:0]  out_row_base;
    logic [OCOL_W-1:0] out_col;

    modport master (
        input  start, shift_cfg, out_ready,
        output busy, done,
        output act_rd_en, act_rd_tile, act_rd_col,
        output wet_rd_en, wet_rd_row, wet_rd_col,
        output PE_mac_enable, PE_clear_acc, PE_res_shift_num,
        output out_valid, out_row_base, out_col
    );

    modport slave (
        output start, shift_cfg, out_ready,
        input  busy, done,
        input  act_rd_en, act_rd_tile, act_rd_col,
        input  wet_rd_en, wet_rd_row, wet_rd_col,
        input  PE_mac_enable, PE_clear_acc, PE_res_shift_num,
        input  out_valid, out_row_base, out_col
    );

endinterface

// File: rtl/pe_ctrl_dly.sv
// N-stage 1-bit delay line; aligns the read-issue strobe with returning SRAM data.
module pe_ctrl_dly #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    // NOTE: the stages are cleared by reset so an abandoned job leaves no stray enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int k = 1; k < N; k++) begin
                sr[k] <= sr[k-1];
            end
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Loop-nest sequencer for the pe_array: m outermost, then row tile j, then reduction index i.
module pe_array_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int MAC_NUM = DEF_MAC_NUM,
    parameter int IA_H    = DEF_IA_H,
    parameter int IA_W    = DEF_IA_W,
    parameter int OA_W    = DEF_OA_W,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int PE_LAT  = DEF_PE_LAT
) (
    input logic             clk,
    input logic             reset,
    pe_array_ctrl_if.master bus
);

    localparam int N_TILES   = IA_H / MAC_NUM;
    localparam int DRAIN_CYC = RD_LAT + PE_LAT;
    // i also times DRAIN, so it must hold whichever bound is larger.
    localparam int I_MAX     = (IA_W > DRAIN_CYC) ? IA_W : DRAIN_CYC;
    localparam int I_W       = clog2_1(I_MAX);
    localparam int J_W       = clog2_1(N_TILES);
    localparam int M_W       = clog2_1(OA_W);
    localparam int COL_W     = clog2_1(IA_W);
    localparam int ROW_W     = clog2_1(IA_H);

    state_e         state_q, state_d;
    logic [I_W-1:0] i_q, i_d;
    logic [J_W-1:0] j_q, j_d;
    logic [M_W-1:0] m_q, m_d;
    logic [7:0]     shift_q, shift_d;

    logic last_i, last_drain, last_j, last_m;
    logic rd_issue, writing, mac_en;

    assign last_i     = (i_q == I_W'(IA_W - 1));
    assign last_drain = (i_q == I_W'(DRAIN_CYC - 1));
    assign last_j     = (j_q == J_W'(N_TILES - 1));
    assign last_m     = (m_q == M_W'(OA_W - 1));
    assign rd_issue   = (state_q == STREAM);
    assign writing    = (state_q == WRITE);

    // NOTE: state and counters use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            m_q     <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            m_q     <= m_d;
            shift_q <= shift_d;
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        m_d     = m_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                    shift_d = bus.shift_cfg;
                end
            end
            CLEAR: begin
                i_d     = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (last_i) begin
                    i_d     = '0;
                    state_d = DRAIN;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DRAIN: begin
                if (last_drain) begin
                    i_d     = '0;
                    state_d = WRITE;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            WRITE: begin
                if (bus.out_ready) begin
                    if (last_j) begin
                        j_d = '0;
                        m_d = last_m ? '0 : m_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    state_d = (last_j && last_m) ? DONE : CLEAR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    pe_ctrl_dly #(
        .N (RD_LAT)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .d     (rd_issue),
        .q     (mac_en)
    );

    // Addresses are forced to zero outside their strobes so idle buses stay quiet.
    always_comb begin
        bus.busy             = (state_q != IDLE);
        bus.done             = (state_q == DONE);
        bus.act_rd_en        = rd_issue;
        bus.act_rd_tile      = rd_issue ? j_q : '0;
        bus.act_rd_col       = rd_issue ? i_q[COL_W-1:0] : '0;
        bus.wet_rd_en        = rd_issue;
        bus.wet_rd_row       = rd_issue ? i_q[COL_W-1:0] : '0;
        bus.wet_rd_col       = rd_issue ? m_q : '0;
        bus.PE_mac_enable    = mac_en;
        bus.PE_clear_acc     = (state_q == CLEAR);
        bus.PE_res_shift_num = shift_q;
        bus.out_valid        = writing;
        bus.out_row_base     = writing ? ROW_W'(int'(j_q) * MAC_NUM) : '0;
        bus.out_col          = writing ? m_q : '0;
    end

endmodule
